// File: rtl/trace_buffer.sv
// Trace buffer: circular capture of {pc, instr, reg_val} around a PC trigger, read back by age index.
// Readout has a 1-cycle latency; there is no backpressure, and capture writes one sample every cycle.
module trace_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] reg_val,
  input  logic             arm,
  input  logic [WIDTH-1:0] trig_pc,
  input  logic [AW:0]      post_len,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_pc,
  output logic [WIDTH-1:0] rd_instr,
  output logic [WIDTH-1:0] rd_val,
  output logic             rd_valid,
  output logic [1:0]       state,
  output logic [AW:0]      count,
  output logic             triggered,
  output logic [AW-1:0]    trig_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] POST  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] MAXPOST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [3*WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr;
  logic [AW:0]   remaining;
  logic [AW:0]   postEff;
  logic [AW:0]   effIn;
  logic [AW:0]   countNext;
  logic [AW:0]   trigIdxArm;
  logic [AW:0]   trigIdxPost;
  logic [AW-1:0] rdAddr;
  logic          capturing;
  logic          rdHit;

  always_comb begin
    effIn       = (post_len > MAXPOST) ? MAXPOST : post_len;
    countNext   = (count == FULL) ? count : count + ONE;
    // Trigger position counts back from the newest entry by the post-trigger length.
    trigIdxArm  = countNext - ONE - effIn;
    trigIdxPost = countNext - ONE - postEff;
    rdAddr      = wrPtr - count[AW-1:0] + rd_idx;
    capturing   = (state == ARMED) || (state == POST);
    rdHit       = (state == DONE) && rd_en && ({1'b0, rd_idx} < count);
  end

  always_ff @(posedge clk) begin
    if (!reset && capturing) begin
      mem[wrPtr] <= {pc, instr, reg_val};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wrPtr     <= '0;
      count     <= '0;
      remaining <= '0;
      postEff   <= '0;
      triggered <= 1'b0;
      trig_idx  <= '0;
      rd_valid  <= 1'b0;
      rd_pc     <= '0;
      rd_instr  <= '0;
      rd_val    <= '0;
    end else begin
      rd_valid <= rdHit;
      if (rdHit) begin
        {rd_pc, rd_instr, rd_val} <= mem[rdAddr];
      end

      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state     <= ARMED;
            wrPtr     <= '0;
            count     <= '0;
            remaining <= '0;
            postEff   <= '0;
            triggered <= 1'b0;
            trig_idx  <= '0;
          end
        end
        ARMED: begin
          wrPtr <= wrPtr + 1'b1;
          count <= countNext;
          if (pc == trig_pc) begin
            triggered <= 1'b1;
            remaining <= effIn;
            postEff   <= effIn;
            if (effIn == '0) begin
              state    <= DONE;
              trig_idx <= trigIdxArm[AW-1:0];
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          wrPtr     <= wrPtr + 1'b1;
          count     <= countNext;
          remaining <= remaining - ONE;
          if (remaining == ONE) begin
            state    <= DONE;
            trig_idx <= trigIdxPost[AW-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the width of the PC, instruction and register-value fields.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of trace entries (power of 2, >=4).
REQ-003 SHALL have derived localparam AW = log2(DEPTH), meaning the entry address width.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pc  input  WIDTH  processor PC sample.
REQ-007 SHALL have port instr  input  WIDTH  processor instruction sample.
REQ-008 SHALL have port reg_val  input  WIDTH  debug register value sample.
REQ-009 SHALL have port arm  input  1  start/restart capture.
REQ-010 SHALL have port trig_pc  input  WIDTH  trigger PC match value.
REQ-011 SHALL have port post_len  input  AW+1  samples to capture after the trigger sample.
REQ-012 SHALL have port rd_en  input  1  readout request.
REQ-013 SHALL have port rd_idx  input  AW  readout index, 0 = oldest entry.
REQ-014 SHALL have ports rd_pc, rd_instr, rd_val  output  WIDTH each  readout data.
REQ-015 SHALL have port rd_valid  output  1  readout data valid.
REQ-016 SHALL have port state  output  2  FSM state: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-017 SHALL have port count  output  AW+1  number of valid entries (0..DEPTH).
REQ-018 SHALL have port triggered  output  1  trigger has fired since the last arm.
REQ-019 SHALL have port trig_idx  output  AW  readout index of the trigger sample.

Function
REQ-020 SHALL write no entries in IDLE; arm=1 -> ARMED next cycle, with wr_ptr, count and triggered cleared.
REQ-021 SHALL, in ARMED, write {pc,instr,reg_val} at wr_ptr every cycle; wr_ptr increments mod DEPTH; count increments and saturates at DEPTH.
REQ-022 SHALL, in ARMED when pc==trig_pc, still write that sample, set triggered=1, and load remaining = min(post_len, DEPTH-1).
REQ-023 SHALL, on trigger with effective post length 0, go to DONE; otherwise go to POST.
REQ-024 SHALL, in POST, write every cycle and decrement remaining; the cycle that writes with remaining==1 moves to DONE.
REQ-025 SHALL ignore trig_pc matches in POST.
REQ-026 SHALL write nothing in DONE; arm=1 in DONE -> ARMED with the same clearing as REQ-020.
REQ-027 SHALL ignore arm in ARMED and POST.
REQ-028 SHALL compute trig_idx on entry to DONE as count-1-effective post length, holding it until the next arm or reset.
REQ-029 SHALL map readout to physical address (wr_ptr - count + rd_idx) mod DEPTH.
REQ-030 SHALL, for rd_en=1 in DONE with rd_idx<count, drive rd_valid=1 with that entry's data on the next cycle (1-cycle latency).
REQ-031 SHALL otherwise drive rd_valid=0 on the next cycle, with rd_pc/rd_instr/rd_val holding their previous values.
REQ-032 SHALL use a storage array of DEPTH x 3*WIDTH with no reset requirement on its contents.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set state=IDLE and clear count, wr_ptr, remaining, triggered, trig_idx, rd_valid, rd_pc, rd_instr and rd_val to 0.
REQ-034 SHALL give reset priority over arm, trigger and rd_en; reset in ARMED or POST aborts capture with no further writes.

Verification (DEPTH=16; after arm, pc = 0x00, 0x04, 0x08, ... one per cycle)
REQ-035 SHALL cover: trig_pc=0x10, post_len=2 -> DONE after pc 0x18 is written, count=7, trig_idx=4, rd_idx0 -> rd_pc=0x00, rd_idx4 -> rd_pc=0x10.
REQ-036 SHALL cover: trig_pc=0x80, post_len=3 -> wrap; count=16, rd_idx0 -> rd_pc=0x50, trig_idx=12, rd_idx12 -> rd_pc=0x80, rd_idx15 -> rd_pc=0x8C.
REQ-037 SHALL cover: trig_pc=0x00, post_len=0 -> DONE one cycle after the first write, count=1, trig_idx=0, rd_idx0 -> rd_pc=0x00.
REQ-038 SHALL cover: trig_pc=0x40, post_len=20 -> clamped to 15; last written pc=0x7C, count=16, trig_idx=0, rd_idx0 -> rd_pc=0x40.
REQ-039 SHALL cover: reset asserted in POST -> next cycle state=0, count=0, triggered=0; rd_en with rd_idx0 -> rd_valid=0.
REQ-040 SHALL cover: in DONE with count=7, rd_idx=7 -> rd_valid=0 and data held; rd_en while ARMED -> rd_valid=0.
